// File: rtl/telemetry_check_pkg.sv
// Shared types and helpers for the telemetry multi-channel checker.
// Holds channel FSM states, packet field offsets and saturating math.
package telemetry_check_pkg;

  localparam int PKT_W  = 88;
  localparam int CLS_HI = 84;
  localparam int CLS_LO = 80;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_ARMING = 2'd1,
    ST_ON     = 2'd2
  } ch_state_e;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        en
  );
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/telemetry_ch_tracker.sv
// Per-channel sequence tracker: FSM, expected count, idle and streak.
// Drop classification is built when TELEMETRY_MULTI_CHECK_DROP_EN is defined.
module telemetry_ch_tracker
  import telemetry_check_pkg::*;
#(
  parameter int          G_CNT_W       = 10,
  parameter logic [19:0] G_MATCH_CNT   = 20'h4ffff,
  parameter logic [15:0] G_TIMEOUT_CNT = 16'hffff,
  parameter int          G_MAX_GAP     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_pkt,
  input  logic [G_CNT_W-1:0] i_cnt,
  output logic               o_mis,
  output logic               o_drop,
  output logic               o_okay_led,
  output logic               o_link_okay
);

  ch_state_e          r_state;
  logic [G_CNT_W-1:0] r_exp;
  logic [15:0]        r_idle;
  logic [19:0]        r_mcnt;
  logic               r_led;
  logic               r_link;
  logic               w_cmp;
  logic               w_match;

  assign w_cmp       = i_pkt && (r_state != ST_UNSYNC);
  assign w_match     = w_cmp && (i_cnt == r_exp);
  assign o_mis       = w_cmp && (i_cnt != r_exp);
  assign o_okay_led  = r_led;
  assign o_link_okay = r_link;

`ifdef TELEMETRY_MULTI_CHECK_DROP_EN
  logic [G_CNT_W-1:0] w_gap;
  assign w_gap  = i_cnt - r_exp;
  assign o_drop = o_mis && (32'(w_gap) <= G_MAX_GAP);
`else
  logic w_unused_gap;
  assign w_unused_gap = ^32'(G_MAX_GAP);
  assign o_drop       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_UNSYNC;
      r_exp   <= '0;
      r_idle  <= '0;
      r_mcnt  <= '0;
      r_led   <= 1'b0;
      r_link  <= 1'b0;
    end else if (i_pkt) begin
      r_idle <= '0;
      r_exp  <= G_CNT_W'(i_cnt + 1'b1);
      unique case (r_state)
        ST_UNSYNC: begin
          r_state <= ST_ARMING;
          r_mcnt  <= '0;
        end
        ST_ARMING: begin
          r_link <= w_match;
          if (!w_match) begin
            r_mcnt <= '0;
          end else if (r_mcnt == G_MATCH_CNT) begin
            r_state <= ST_ON;
            r_led   <= 1'b1;
          end else begin
            r_mcnt <= r_mcnt + 20'd1;
          end
        end
        ST_ON: begin
          r_link <= w_match;
          if (!w_match) begin
            r_state <= ST_ARMING;
            r_mcnt  <= '0;
            r_led   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_UNSYNC;
          r_led   <= 1'b0;
          r_link  <= 1'b0;
        end
      endcase
    end else begin
      if (r_idle != G_TIMEOUT_CNT)
        r_idle <= r_idle + 16'd1;
      // a packet in the same cycle takes the branch above instead
      if (r_idle == G_TIMEOUT_CNT && r_state != ST_UNSYNC) begin
        r_state <= ST_UNSYNC;
        r_mcnt  <= '0;
        r_led   <= 1'b0;
        r_link  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/telemetry_multi_check.sv
// Multi-channel telemetry sequence checker with saturating statistics.
// Optional drop counter: define TELEMETRY_MULTI_CHECK_DROP_EN.
module telemetry_multi_check
  import telemetry_check_pkg::*;
#(
  parameter int          G_NUM_CH      = 2,
  parameter logic [3:0]  G_CLASS_BASE  = 4'hD,
  parameter int          G_CNT_W       = 10,
  parameter logic [19:0] G_MATCH_CNT   = 20'h4ffff,
  parameter logic [15:0] G_TIMEOUT_CNT = 16'hffff,
  parameter int          G_MAX_GAP     = 4
) (
  input  logic                clk_256M,
  input  logic                rst_n,
  input  logic [PKT_W-1:0]    packet_data,
  input  logic                packet_valid,
  input  logic                reset_counters,
  input  logic [2:0]          ch_sel,
  output logic [31:0]         total_packets,
  output logic [31:0]         checked_packets,
  output logic [31:0]         mismatch_packets,
  output logic [31:0]         ch_mismatch,
  output logic [31:0]         drop_packets,
  output logic [G_NUM_CH-1:0] ch_okay_led,
  output logic [G_NUM_CH-1:0] ch_link_okay,
  output logic                okay_led
);

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  logic [3:0]          w_idx;
  logic [G_NUM_CH-1:0] w_hit;
  logic [G_NUM_CH-1:0] w_mis;
  logic [G_NUM_CH-1:0] w_drop;
  logic                w_chk;
  logic                w_any_mis;
  logic                w_unused;

  logic [31:0] r_total;
  logic [31:0] r_checked;
  logic [31:0] r_mis;
  logic [31:0] r_ch_mux;
  logic [31:0] r_ch_cnt [G_NUM_CH];
  logic [31:0] w_ch_nxt [G_NUM_CH];
  logic [31:0] w_sel_nxt;

  // reset asserts immediately, releases after two clock edges
  always_ff @(posedge clk_256M or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_idx = packet_data[CLS_HI-1:CLS_LO] - G_CLASS_BASE;

  always_comb begin
    w_hit = '0;
    for (int c = 0; c < G_NUM_CH; c++)
      w_hit[c] = packet_valid && (w_idx == 4'(c));
  end

  assign w_chk     = |w_hit;
  assign w_any_mis = |w_mis;

  for (genvar c = 0; c < G_NUM_CH; c++) begin : g_ch
    telemetry_ch_tracker #(
      .G_CNT_W      (G_CNT_W),
      .G_MATCH_CNT  (G_MATCH_CNT),
      .G_TIMEOUT_CNT(G_TIMEOUT_CNT),
      .G_MAX_GAP    (G_MAX_GAP)
    ) u_trk (
      .clk        (clk_256M),
      .rst_n      (w_rst_n),
      .i_pkt      (w_hit[c]),
      .i_cnt      (packet_data[G_CNT_W-1:0]),
      .o_mis      (w_mis[c]),
      .o_drop     (w_drop[c]),
      .o_okay_led (ch_okay_led[c]),
      .o_link_okay(ch_link_okay[c])
    );
  end

  assign okay_led = &ch_okay_led;

  // mux the next value so a new packet is visible in one cycle
  always_comb begin
    w_sel_nxt = '0;
    for (int c = 0; c < G_NUM_CH; c++) begin
      w_ch_nxt[c] = reset_counters ? '0 : sat_inc(r_ch_cnt[c], w_mis[c]);
      if (ch_sel == 3'(c))
        w_sel_nxt = w_ch_nxt[c];
    end
  end

  always_ff @(posedge clk_256M or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_total   <= '0;
      r_checked <= '0;
      r_mis     <= '0;
      r_ch_mux  <= '0;
      for (int c = 0; c < G_NUM_CH; c++)
        r_ch_cnt[c] <= '0;
    end else begin
      r_ch_mux <= w_sel_nxt;
      for (int c = 0; c < G_NUM_CH; c++)
        r_ch_cnt[c] <= w_ch_nxt[c];
      if (reset_counters) begin
        r_total   <= '0;
        r_checked <= '0;
        r_mis     <= '0;
      end else begin
        r_total   <= sat_inc(r_total, packet_valid);
        r_checked <= sat_inc(r_checked, w_chk);
        r_mis     <= sat_inc(r_mis, w_any_mis);
      end
    end
  end

  assign total_packets    = r_total;
  assign checked_packets  = r_checked;
  assign mismatch_packets = r_mis;
  assign ch_mismatch      = r_ch_mux;

`ifdef TELEMETRY_MULTI_CHECK_DROP_EN
  logic [31:0] r_drop;

  always_ff @(posedge clk_256M or negedge w_rst_n) begin
    if (!w_rst_n)            r_drop <= '0;
    else if (reset_counters) r_drop <= '0;
    else                     r_drop <= sat_inc(r_drop, |w_drop);
  end

  assign drop_packets = r_drop;
  assign w_unused = ^{packet_data[PKT_W-1:CLS_HI],
                      packet_data[CLS_LO-1:G_CNT_W]};
`else
  assign drop_packets = '0;
  assign w_unused = ^{packet_data[PKT_W-1:CLS_HI],
                      packet_data[CLS_LO-1:G_CNT_W], w_drop};
`endif

endmodule

// File: tb/tb_telemetry_multi_check.sv
// Directed bench for telemetry_multi_check (2 channels, short match/timeout).
// Drop expectations follow TELEMETRY_MULTI_CHECK_DROP_EN.
module tb_telemetry_multi_check;

`ifdef TELEMETRY_MULTI_CHECK_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [87:0] packet_data;
  logic        packet_valid;
  logic        reset_counters;
  logic [2:0]  ch_sel;
  logic [31:0] total_packets;
  logic [31:0] checked_packets;
  logic [31:0] mismatch_packets;
  logic [31:0] ch_mismatch;
  logic [31:0] drop_packets;
  logic [1:0]  ch_okay_led;
  logic [1:0]  ch_link_okay;
  logic        okay_led;

  int n_chk = 0;
  int n_err = 0;

  always #2 clk = ~clk;

  telemetry_multi_check #(
    .G_NUM_CH     (2),
    .G_CLASS_BASE (4'hD),
    .G_CNT_W      (10),
    .G_MATCH_CNT  (20'd16),
    .G_TIMEOUT_CNT(16'd20),
    .G_MAX_GAP    (4)
  ) dut (
    .clk_256M        (clk),
    .rst_n           (rst_n),
    .packet_data     (packet_data),
    .packet_valid    (packet_valid),
    .reset_counters  (reset_counters),
    .ch_sel          (ch_sel),
    .total_packets   (total_packets),
    .checked_packets (checked_packets),
    .mismatch_packets(mismatch_packets),
    .ch_mismatch     (ch_mismatch),
    .drop_packets    (drop_packets),
    .ch_okay_led     (ch_okay_led),
    .ch_link_okay    (ch_link_okay),
    .okay_led        (okay_led)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic pkt(input logic [3:0] cls, input int cnt,
                     input logic rc);
    @(negedge clk);
    packet_data        = '0;
    packet_data[87:84] = 4'h5;
    packet_data[50]    = 1'b1;
    packet_data[83:80] = cls;
    packet_data[9:0]   = cnt[9:0];
    packet_valid       = 1'b1;
    reset_counters     = rc;
    @(posedge clk); #1;
    packet_valid   = 1'b0;
    reset_counters = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    @(negedge clk);
    reset_counters = 1'b1;
    @(posedge clk); #1;
    reset_counters = 1'b0;
  endtask

  function automatic logic [31:0] dexp(input int n);
    return DROP ? 32'(n) : 32'd0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    packet_data = '0;
    packet_valid = 1'b0;
    reset_counters = 1'b0;
    ch_sel = 3'd0;
    idle(3);
    chk("rst_total", total_packets, 0);
    chk("rst_led", {30'd0, ch_okay_led}, 0);
    chk("rst_link", {30'd0, ch_link_okay}, 0);
    chk("rst_okay", {31'd0, okay_led}, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(3);

    // wrap stream on channel 0
    for (int k = 0; k < 1026; k++) begin
      pkt(4'hD, k % 1024, 1'b0);
      if (k == 16) chk("led_before17", {31'd0, ch_okay_led[0]}, 0);
      if (k == 17) chk("led_after17", {31'd0, ch_okay_led[0]}, 1);
    end
    chk("wrap_mis", mismatch_packets, 0);
    chk("wrap_total", total_packets, 1026);
    chk("wrap_checked", checked_packets, 1026);
    chk("wrap_led", {31'd0, ch_okay_led[0]}, 1);
    chk("wrap_link", {31'd0, ch_link_okay[0]}, 1);
    chk("wrap_okay", {31'd0, okay_led}, 0);

    idle(25);
    chk("to0_led", {31'd0, ch_okay_led[0]}, 0);
    chk("to0_link", {31'd0, ch_link_okay[0]}, 0);
    clr();
    chk("clr_total", total_packets, 0);

    // single drop: 5,6,8,9
    pkt(4'hD, 5, 1'b0);
    pkt(4'hD, 6, 1'b0);
    chk("t2_link6", {31'd0, ch_link_okay[0]}, 1);
    pkt(4'hD, 8, 1'b0);
    chk("t2_link8", {31'd0, ch_link_okay[0]}, 0);
    chk("t2_mis8", mismatch_packets, 1);
    pkt(4'hD, 9, 1'b0);
    chk("t2_link9", {31'd0, ch_link_okay[0]}, 1);
    chk("t2_mis", mismatch_packets, 1);
    chk("t2_chmis", ch_mismatch, 1);
    chk("t2_total", total_packets, 4);
    chk("t2_drop", drop_packets, dexp(1));

    // streak then corruption and gap boundaries
    for (int k = 10; k <= 30; k++) pkt(4'hD, k, 1'b0);
    chk("t3_led_on", {31'd0, ch_okay_led[0]}, 1);
    pkt(4'hD, 31, 1'b0);
    pkt(4'hD, 32, 1'b0);
    pkt(4'hD, 99, 1'b0);
    chk("t3_led_off", {31'd0, ch_okay_led[0]}, 0);
    chk("t3_mis99", mismatch_packets, 2);
    pkt(4'hD, 34, 1'b0);
    chk("t3_mis34", mismatch_packets, 3);
    chk("t3_drop34", drop_packets, dexp(1));
    pkt(4'hD, 39, 1'b0);
    chk("t3_drop_gap4", drop_packets, dexp(2));
    pkt(4'hD, 40, 1'b0);
    pkt(4'hD, 46, 1'b0);
    chk("t3_drop_gap5", drop_packets, dexp(2));
    chk("t3_mis46", mismatch_packets, 5);
    pkt(4'hD, 47, 1'b0);
    chk("t3_link47", {31'd0, ch_link_okay[0]}, 1);

    // interleaved classes
    ch_sel = 3'd1;
    clr();
    pkt(4'hE, 100, 1'b0);
    pkt(4'hD, 48, 1'b0);
    pkt(4'h3, 7, 1'b0);
    pkt(4'hE, 101, 1'b0);
    pkt(4'hE, 103, 1'b0);
    pkt(4'hD, 49, 1'b0);
    pkt(4'h3, 0, 1'b0);
    pkt(4'hD, 51, 1'b0);
    pkt(4'hE, 104, 1'b0);
    pkt(4'hD, 55, 1'b0);
    chk("t5_total", total_packets, 10);
    chk("t5_checked", checked_packets, 8);
    chk("t5_mis", mismatch_packets, 3);
    chk("t5_ch1", ch_mismatch, 1);
    chk("t5_drop", drop_packets, dexp(3));
    ch_sel = 3'd0;
    #1;
    chk("t5_sel_lag", ch_mismatch, 1);
    idle(1);
    chk("t5_ch0", ch_mismatch, 2);
    ch_sel = 3'd2;
    idle(1);
    chk("t5_ch2", ch_mismatch, 0);
    ch_sel = 3'd0;

    // both channels on, then channel 1 times out
    for (int i = 0; i <= 20; i++) begin
      pkt(4'hD, 56 + i, 1'b0);
      pkt(4'hE, 105 + i, 1'b0);
    end
    chk("t6_okay", {31'd0, okay_led}, 1);
    for (int k = 77; k <= 96; k++) pkt(4'hD, k, 1'b0);
    chk("t6_led1_hold", {31'd0, ch_okay_led[1]}, 1);
    pkt(4'hD, 97, 1'b0);
    chk("t6_led1_to", {31'd0, ch_okay_led[1]}, 0);
    chk("t6_link1_to", {31'd0, ch_link_okay[1]}, 0);
    chk("t6_okay_to", {31'd0, okay_led}, 0);
    pkt(4'hE, 500, 1'b0);
    chk("t6_reseed_mis", mismatch_packets, 3);
    chk("t6_reseed_link", {31'd0, ch_link_okay[1]}, 0);
    pkt(4'hE, 501, 1'b0);
    chk("t6_link1", {31'd0, ch_link_okay[1]}, 1);
    chk("t6_mis", mismatch_packets, 3);

    // clear with a mismatching packet
    pkt(4'hD, 200, 1'b1);
    chk("t7_total", total_packets, 0);
    chk("t7_checked", checked_packets, 0);
    chk("t7_mis", mismatch_packets, 0);
    chk("t7_chmis", ch_mismatch, 0);
    chk("t7_drop", drop_packets, 0);
    chk("t7_link", {31'd0, ch_link_okay[0]}, 0);
    pkt(4'hD, 201, 1'b0);
    chk("t7_mis201", mismatch_packets, 0);
    chk("t7_link201", {31'd0, ch_link_okay[0]}, 1);
    chk("t7_total201", total_packets, 1);

    // reset pulse mid-stream
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("t8_total", total_packets, 0);
    chk("t8_checked", checked_packets, 0);
    chk("t8_link", {30'd0, ch_link_okay}, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(3);
    pkt(4'hD, 300, 1'b0);
    pkt(4'hD, 301, 1'b0);
    chk("t8_mis", mismatch_packets, 0);
    chk("t8_link301", {31'd0, ch_link_okay[0]}, 1);
    chk("t8_total2", total_packets, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/telemetry_multi_check.md
# telemetry_multi_check

Parametrised multi-channel sequence checker for the telemetry packet stream on the 256 MHz clock. It tracks an independent wrapping counter in each of G_NUM_CH consecutive class IDs, keeps saturating per-channel and aggregate statistics, and drives per-channel and aggregate link-health indicators. It sits after packet unpack, in parallel with the stream consumers, and pairs with the multi-channel test-counter generator.

## Interface
- G_NUM_CH, 2: channels checked, 1..8; channel c = class ID (G_CLASS_BASE + c) mod 16.
- G_CLASS_BASE, 4'hD: class ID of channel 0.
- G_CNT_W, 10: counter width in packet_data[G_CNT_W-1:0], 1..16.
- G_MATCH_CNT, 20'h4ffff: consecutive matches before a channel LED turns on.
- G_TIMEOUT_CNT, 16'hffff: idle cycles per channel before it is declared dead.
- G_MAX_GAP, 4: largest forward jump classed as drop (drop feature only).
- clk_256M  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- packet_data  in  88  packet; class ID [83:80].
- packet_valid  in  1  one packet per asserted cycle; no backpressure.
- reset_counters  in  1  synchronous clear of statistics.
- ch_sel  in  3  channel selected for ch_mismatch.
- total_packets  out  32  all valid packets, any class.
- checked_packets  out  32  packets on checked channels.
- mismatch_packets  out  32  mismatches, all channels.
- ch_mismatch  out  32  mismatches of channel ch_sel (0 if ch_sel >= G_NUM_CH).
- drop_packets  out  32  drop-classified mismatches (feature only).
- ch_okay_led  out  G_NUM_CH  per-channel long-streak indicator.
- ch_link_okay  out  G_NUM_CH  per-channel fast indicator.
- okay_led  out  1  AND of ch_okay_led.

## Operation
- Decode: idx = class ID − G_CLASS_BASE (4-bit wrap); packet checked iff idx < G_NUM_CH. Other classes count only toward total_packets.
- Per-channel FSM: UNSYNC, ARMING, ON.
  - UNSYNC: first checked packet seeds expected = cnt+1, no compare, no mismatch; → ARMING, match_cnt = 0.
  - ARMING: match → match_cnt+1; when match_cnt reaches G_MATCH_CNT → ON. Mismatch → ARMING, match_cnt = 0.
  - ON: match stays ON; mismatch → ARMING, match_cnt = 0.
  - Timeout (idle counter == G_TIMEOUT_CNT) in ARMING or ON → UNSYNC.
- Every checked packet, matched or not, sets expected = cnt+1 mod 2^G_CNT_W, so one drop costs one mismatch and one corrupted value costs two.
- ch_okay_led = state ON. ch_link_okay = 1 after a match, 0 after a mismatch, timeout or entry to UNSYNC.
- Idle counter per channel: cleared by that channel's packet, otherwise +1, holding at G_TIMEOUT_CNT.
- All statistics counters saturate at 32'hFFFFFFFF and never wrap.
- reset_counters clears statistics only. FSMs, expected values and idle counters are unaffected.

## Timing
- rst_n low: all outputs 0, all FSMs UNSYNC, expected 0, idle and match counters 0.
- Single-cycle latency: all outputs reflect a packet on the edge that samples packet_valid. Back-to-back packets on the same channel are legal every cycle.
- ch_mismatch is a registered mux: ch_sel change is visible after 1 cycle.
- reset_counters with packet_valid in the same cycle: clear wins and the packet is not counted. The FSM, expected value and idle counter still update.
- Counter wrap: a cnt of 2^G_CNT_W−1 followed by 0 is a match.
- Timeout and packet on the same channel in the same cycle: the packet wins.
- rst_n deassertion is synchronised internally (2 flops) before FSMs leave reset.

## Configuration
- TELEMETRY_MULTI_CHECK_DROP_EN defined: a mismatch with (cnt − expected) mod 2^G_CNT_W in 1..G_MAX_GAP also increments drop_packets. It still counts as a mismatch and still breaks the streak.
- Not defined: drop_packets is tied to 0 and no gap logic is built.

## Structure
- Package telemetry_check_pkg holds the FSM state enum, the class-ID field offsets (84/80), the 88-bit packet width, and the saturating-increment function.
- One sub-module, telemetry_ch_tracker, instantiated G_NUM_CH times in a generate loop. It contains the FSM, expected value, idle counter, match counter and LED outputs.
- Statistics, decode and mux stay at top level.

## Test plan
- Channel 0 (class D) sends 0..1023, 0, 1 with G_MATCH_CNT = 16: mismatch_packets = 0, ch_okay_led[0] rises after the 17th match, and the wrap is clean.
- Channel 0 sends 5, 6, 8, 9: mismatch_packets = 1 and ch_link_okay[0] low for exactly one packet. With DROP_EN, drop_packets = 1.
- Channel 0 sends 5, 6, 99, 8: mismatch_packets = 2, drop_packets = 0, and ch_okay_led[0] is cleared.
- Interleaved classes D, E, 3 with G_NUM_CH = 2: checked_packets = D+E count, total_packets includes class 3, and ch_sel = 1 returns only class E mismatches.
- Channel 1 silent for G_TIMEOUT_CNT+1 cycles: ch_okay_led[1] and ch_link_okay[1] go to 0, and the next arbitrary value reseeds with no mismatch.
- reset_counters in the same cycle as a mismatching packet: all statistics read 0 next cycle and the following in-sequence packet matches. rst_n pulsed mid-stream: all outputs 0 and the FSMs resynchronise.
